// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx
// Device-side PS/2 transmitter. Bytes written through i_din/i_din_wr are
// queued in a small FIFO and sent one by one as 11-bit PS/2 frames
// (start, d0..d7, odd parity, stop) on released-high clock/data lines.
// A host inhibit cancels the frame in progress. The same byte is then
// resent once the host has released the clock for a full idle gap.
//
// Ports
//   i_clk_sys      system clock, the only clock
//   i_reset        synchronous active-high reset
//   i_din          byte to queue
//   i_din_wr       one-cycle write strobe for i_din
//   i_inhibit      host is holding the clock low (already synchronised)
//   o_ps2_clk_out  PS/2 clock line, 1 = released
//   o_ps2_dat_out  PS/2 data line, 1 = released
//   o_full         FIFO holds FIFO_DEPTH bytes
//   o_busy         frame machine active or bytes still queued
//   o_overflow     one-cycle pulse when a write is dropped on a full FIFO
module ps2_dev_tx #(
    parameter int CLK_HZ     = 21477270,
    parameter int PS2_HZ     = 12000,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_BITS   = 2
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic [7:0] i_din,
    input  logic       i_din_wr,
    input  logic       i_inhibit,
    output logic       o_ps2_clk_out,
    output logic       o_ps2_dat_out,
    output logic       o_full,
    output logic       o_busy,
    output logic       o_overflow
);

    // HALF is the length of one clock phase. GAP_CYC is the idle time
    // enforced after every frame and after every abort. GAP_BITS is
    // expected to be at least 1.
    localparam int HALF    = CLK_HZ / (2 * PS2_HZ);
    localparam int GAP_CYC = GAP_BITS * 2 * HALF;
    localparam int PH_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [PH_W-1:0]  HALF_LAST = PH_W'(HALF - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       STOP_IDX  = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } txState_t;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    // Frame machine state
    txState_t         r_state;
    logic [3:0]       r_bitIdx;
    logic             r_phaseLow;
    logic [PH_W-1:0]  r_phaseCnt;
    logic [GAP_W-1:0] r_gapCnt;
    logic             r_ps2Clk;
    logic             r_ps2Dat;

    // Next-state values from the frame machine
    txState_t         w_stateNext;
    logic [3:0]       w_bitNext;
    logic             w_phaseLowNext;
    logic [PH_W-1:0]  w_phaseCntNext;
    logic [GAP_W-1:0] w_gapCntNext;
    logic             w_clkNext;
    logic             w_datNext;
    logic             w_pop;

    logic             w_full;
    logic             w_push;
    logic [7:0]       w_headByte;
    logic [10:0]      w_frameBits;

    assign w_full     = (r_count == FULL_CNT);
    // A full FIFO still accepts a write in the cycle its head is popped.
    assign w_push     = i_din_wr && (!w_full || w_pop);
    assign w_headByte = r_mem[r_rdPtr];
    // Bit 0 goes out first. Parity is odd over the data byte.
    assign w_frameBits = {1'b1, ~^w_headByte, w_headByte, 1'b0};

    // Byte storage. It needs no reset because the pointers decide what is valid.
    always_ff @(posedge i_clk_sys) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    // FIFO pointers and occupancy. The head is only released after its
    // stop bit, so an aborted frame finds the same byte at the head again.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Frame machine state register. The line drivers are registered here
    // too, so the open-drain outputs never glitch between states.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_bitIdx   <= '0;
            r_phaseLow <= 1'b0;
            r_phaseCnt <= '0;
            r_gapCnt   <= '0;
            r_ps2Clk   <= 1'b1;
            r_ps2Dat   <= 1'b1;
        end else begin
            r_state    <= w_stateNext;
            r_bitIdx   <= w_bitNext;
            r_phaseLow <= w_phaseLowNext;
            r_phaseCnt <= w_phaseCntNext;
            r_gapCnt   <= w_gapCntNext;
            r_ps2Clk   <= w_clkNext;
            r_ps2Dat   <= w_datNext;
        end
    end

    // Frame machine next-state logic. Each bit is a high phase (the data
    // changes on its first cycle) followed by a low phase of equal length.
    // Host inhibit beats everything else, even on the last cycle of the
    // stop bit, and always leads through the full idle gap.
    always_comb begin
        w_stateNext    = r_state;
        w_bitNext      = r_bitIdx;
        w_phaseLowNext = r_phaseLow;
        w_phaseCntNext = r_phaseCnt;
        w_gapCntNext   = r_gapCnt;
        w_clkNext      = 1'b1;
        w_datNext      = 1'b1;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_inhibit) begin
                    // Hold off so the device never starts right after a release.
                    w_stateNext  = GAP;
                    w_gapCntNext = '0;
                end else if (r_count != '0) begin
                    w_stateNext    = SEND;
                    w_bitNext      = '0;
                    w_phaseLowNext = 1'b0;
                    w_phaseCntNext = '0;
                    w_datNext      = 1'b0;
                end
            end

            SEND: begin
                if (i_inhibit) begin
                    w_stateNext  = GAP;
                    w_gapCntNext = '0;
                end else if (r_phaseCnt != HALF_LAST) begin
                    w_phaseCntNext = r_phaseCnt + 1'b1;
                    w_clkNext      = !r_phaseLow;
                    w_datNext      = w_frameBits[r_bitIdx];
                end else if (!r_phaseLow) begin
                    w_phaseCntNext = '0;
                    w_phaseLowNext = 1'b1;
                    w_clkNext      = 1'b0;
                    w_datNext      = w_frameBits[r_bitIdx];
                end else if (r_bitIdx == STOP_IDX) begin
                    w_pop          = 1'b1;
                    w_stateNext    = GAP;
                    w_gapCntNext   = '0;
                    w_phaseCntNext = '0;
                    w_phaseLowNext = 1'b0;
                    w_bitNext      = '0;
                end else begin
                    w_phaseCntNext = '0;
                    w_phaseLowNext = 1'b0;
                    w_bitNext      = r_bitIdx + 4'd1;
                    w_datNext      = w_frameBits[r_bitIdx + 4'd1];
                end
            end

            GAP: begin
                if (i_inhibit) begin
                    w_gapCntNext = '0;
                end else if (r_gapCnt == GAP_LAST) begin
                    w_stateNext  = IDLE;
                    w_gapCntNext = '0;
                end else begin
                    w_gapCntNext = r_gapCnt + 1'b1;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign o_ps2_clk_out = r_ps2Clk;
    assign o_ps2_dat_out = r_ps2Dat;
    assign o_full        = w_full;
    assign o_busy        = (r_state != IDLE) || (r_count != '0);
    assign o_overflow    = i_din_wr && w_full && !w_pop;

endmodule
